// File: rtl/epidemic_node.sv
// Epidemic (flood) routing mesh node: four input FIFOs, round-robin pop, seen-ID cache, multicast stage.
// Optional drop counter output o_drop_cnt is enabled by defining NODE_DROP_CNT_EN.

module epidemic_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rp, wp;
  logic [AW:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module epidemic_node #(
  parameter int DATA_W  = 16,
  parameter int ID_W    = 6,
  parameter int TTL_W   = 3,
  parameter int DEPTH   = 4,
  parameter int CACHE_N = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid_l,
  input  logic [DATA_W-1:0] i_data_l,
  output logic              o_ready_l,
  output logic              o_valid_l,
  output logic [DATA_W-1:0] o_data_l,
  input  logic              i_ready_l,
  input  logic              i_valid_r,
  input  logic [DATA_W-1:0] i_data_r,
  output logic              o_ready_r,
  output logic              o_valid_r,
  output logic [DATA_W-1:0] o_data_r,
  input  logic              i_ready_r,
  input  logic              i_valid_t,
  input  logic [DATA_W-1:0] i_data_t,
  output logic              o_ready_t,
  output logic              o_valid_t,
  output logic [DATA_W-1:0] o_data_t,
  input  logic              i_ready_t,
  input  logic              i_valid_b,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_ready_b,
  output logic              o_valid_b,
  output logic [DATA_W-1:0] o_data_b,
  input  logic              i_ready_b
`ifdef NODE_DROP_CNT_EN
  , output logic [15:0]     o_drop_cnt
`endif
);
  localparam int NP     = 4;
  localparam int PAY_W  = DATA_W - ID_W - TTL_W;
  localparam int CW     = (CACHE_N > 1) ? $clog2(CACHE_N) : 1;

  logic [NP-1:0]             in_vld, out_rdy, push, pop, empty, full;
  logic [NP-1:0][DATA_W-1:0] in_data, head;

  assign in_vld  = {i_valid_b, i_valid_t, i_valid_r, i_valid_l};
  assign out_rdy = {i_ready_b, i_ready_t, i_ready_r, i_ready_l};
  assign in_data = {i_data_b, i_data_t, i_data_r, i_data_l};
  assign push    = in_vld & ~full;
  assign {o_ready_b, o_ready_t, o_ready_r, o_ready_l} = ~full;

  generate
    for (genvar p = 0; p < NP; p++) begin : g_port
      epidemic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rstn), .push(push[p]), .din(in_data[p]),
        .pop(pop[p]), .head(head[p]), .empty(empty[p]), .full(full[p])
      );
    end
  endgenerate

  logic [DATA_W-1:0]            st_flit;
  logic [NP-1:0]                st_mask;
  logic [1:0]                   rr, gnt, idx;
  logic [CACHE_N-1:0][ID_W-1:0] cache_id;
  logic [CACHE_N-1:0]           cache_vld;
  logic [CW-1:0]                wptr;
  logic                         free, gnt_vld, hit, take, drop, fwd;
  logic [DATA_W-1:0]            g_head;
  logic [ID_W-1:0]              g_id;
  logic [TTL_W-1:0]             g_ttl;

  // Stage frees in the same cycle its last pending target accepts, enabling back-to-back reloads.
  assign free = ((st_mask & ~out_rdy) == '0);

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = rr;
    idx     = rr;
    for (int k = NP-1; k >= 0; k--) begin
      idx = rr + 2'(k);
      if (!empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    g_head = head[gnt];
    g_id   = g_head[DATA_W-1 -: ID_W];
    g_ttl  = g_head[DATA_W-ID_W-1 -: TTL_W];
    hit    = 1'b0;
    for (int i = 0; i < CACHE_N; i++)
      if (cache_vld[i] && cache_id[i] == g_id) hit = 1'b1;
    take = free && gnt_vld;
    drop = take && (g_ttl == '0 || hit);
    fwd  = take && !drop;
    pop  = take ? (4'b0001 << gnt) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      st_flit   <= '0;
      st_mask   <= '0;
      rr        <= '0;
      cache_id  <= '0;
      cache_vld <= '0;
      wptr      <= '0;
    end else if (fwd) begin
      st_flit         <= {g_id, g_ttl - 1'b1, g_head[PAY_W-1:0]};
      st_mask         <= ~(4'b0001 << gnt);
      rr              <= gnt + 2'd1;
      cache_id[wptr]  <= g_id;
      cache_vld[wptr] <= 1'b1;
      wptr            <= (wptr == CW'(CACHE_N-1)) ? '0 : wptr + 1'b1;
    end else begin
      st_mask <= st_mask & ~out_rdy;
      if (take) rr <= gnt + 2'd1;
    end
  end

  assign {o_valid_b, o_valid_t, o_valid_r, o_valid_l} = st_mask;
  assign o_data_l = st_flit;
  assign o_data_r = st_flit;
  assign o_data_t = st_flit;
  assign o_data_b = st_flit;

`ifdef NODE_DROP_CNT_EN
  logic [15:0] drop_cnt;
  always_ff @(posedge clk) begin
    if (rstn) drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
  assign o_drop_cnt = drop_cnt;
`endif
endmodule

// File: tb/tb_epidemic_node.sv
// Bench for epidemic_node: vector table, directed multi-cycle sequences, random traffic vs queue-based model.
module tb_epidemic_node;
  localparam int DATA_W = 16, ID_W = 6, TTL_W = 3, DEPTH = 4, CACHE_N = 8;
  localparam int PAY_W = DATA_W - ID_W - TTL_W;
  typedef logic [DATA_W-1:0] flit_t;

  logic clk = 1'b0;
  logic rstn;
  logic [3:0] iv, ir;
  flit_t idat [4];
  wire [3:0] ov, ordy;
  wire [DATA_W-1:0] odat [4];
`ifdef NODE_DROP_CNT_EN
  wire [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  epidemic_node #(.DATA_W(DATA_W), .ID_W(ID_W), .TTL_W(TTL_W), .DEPTH(DEPTH), .CACHE_N(CACHE_N)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid_l(iv[0]), .i_data_l(idat[0]), .o_ready_l(ordy[0]), .o_valid_l(ov[0]), .o_data_l(odat[0]), .i_ready_l(ir[0]),
    .i_valid_r(iv[1]), .i_data_r(idat[1]), .o_ready_r(ordy[1]), .o_valid_r(ov[1]), .o_data_r(odat[1]), .i_ready_r(ir[1]),
    .i_valid_t(iv[2]), .i_data_t(idat[2]), .o_ready_t(ordy[2]), .o_valid_t(ov[2]), .o_data_t(odat[2]), .i_ready_t(ir[2]),
    .i_valid_b(iv[3]), .i_data_b(idat[3]), .o_ready_b(ordy[3]), .o_valid_b(ov[3]), .o_data_b(odat[3]), .i_ready_b(ir[3])
`ifdef NODE_DROP_CNT_EN
    , .o_drop_cnt(drop_cnt)
`endif
  );

  int n_cmp = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic flit_t mkf(input int id, input int ttl, input int pay);
    logic [ID_W-1:0] a;
    logic [TTL_W-1:0] b;
    logic [PAY_W-1:0] c;
    a = id[ID_W-1:0];
    b = ttl[TTL_W-1:0];
    c = pay[PAY_W-1:0];
    return {a, b, c};
  endfunction

  // Reference model: per-port queues, a list of the last CACHE_N forwarded IDs, one multicast slot.
  flit_t mq[4][$];
  int m_cache[$];
  int m_rr, m_g, m_id, m_ttl, m_drops;
  logic [3:0] m_mask, m_push;
  flit_t m_flit, m_f;
  bit m_free, m_hit;

  always @(posedge clk) begin
    if (rstn) begin
      for (int p = 0; p < 4; p++) mq[p].delete();
      m_cache.delete();
      m_mask = '0; m_rr = 0; m_drops = 0;
    end else begin
      for (int p = 0; p < 4; p++) m_push[p] = iv[p] && (mq[p].size() < DEPTH);
      m_free = ((m_mask & ~ir) == 4'b0);
      m_mask = m_mask & ~ir;
      if (m_free) begin
        m_g = -1;
        for (int k = 0; k < 4; k++)
          if (m_g < 0 && mq[(m_rr + k) % 4].size() > 0) m_g = (m_rr + k) % 4;
        if (m_g >= 0) begin
          m_f = mq[m_g].pop_front();
          m_rr = (m_g + 1) % 4;
          m_id = int'(m_f[DATA_W-1 -: ID_W]);
          m_ttl = int'(m_f[DATA_W-ID_W-1 -: TTL_W]);
          m_hit = 0;
          foreach (m_cache[j]) if (m_cache[j] == m_id) m_hit = 1;
          if (m_ttl == 0 || m_hit) m_drops++;
          else begin
            m_flit = mkf(m_id, m_ttl - 1, int'(m_f[PAY_W-1:0]));
            m_mask = 4'b1111 & ~(4'b0001 << m_g);
            m_cache.push_back(m_id);
            if (m_cache.size() > CACHE_N) void'(m_cache.pop_front());
          end
        end
      end
      for (int p = 0; p < 4; p++) if (m_push[p]) mq[p].push_back(idat[p]);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("mdl_valid%0d", p), ov[p], m_mask[p]);
        if (m_mask[p]) chk($sformatf("mdl_data%0d", p), odat[p], m_flit);
        chk($sformatf("mdl_ready%0d", p), ordy[p], mq[p].size() < DEPTH);
      end
`ifdef NODE_DROP_CNT_EN
      chk("mdl_drop_cnt", drop_cnt, (m_drops > 32'hFFFF) ? 32'hFFFF : m_drops);
`endif
    end
  end

  // Handshake monitor, independent of the model.
  int seen [4][64];
  flit_t tq[4][$];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int p = 0; p < 4; p++) begin
        if (ov[p] && ir[p]) begin
          seen[p][odat[p][DATA_W-1 -: ID_W]]++;
          tq[p].push_back(odat[p]);
        end
      end
    end
  end

  task automatic clr_mon();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) seen[p][i] = 0;
      tq[p].delete();
    end
  endtask

  task automatic send(input int p, input flit_t f);
    int t;
    t = 0;
    iv[p] = 1'b1;
    idat[p] = f;
    while (!ordy[p] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", 0, 1);
    @(negedge clk);
    iv[p] = 1'b0;
  endtask

  typedef struct {
    int port; int id; int ttl; int pay;
    logic [3:0] mask;
    flit_t dat;
  } vec_t;
  vec_t tv[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 5, 3, 'h2A, 4'b1110, mkf(5, 2, 'h2A)};
    tv[1] = '{3, 5, 3, 'h11, 4'b0000, '0};
    tv[2] = '{1, 7, 0, 'h05, 4'b0000, '0};
    tv[3] = '{2, 20, 7, 'h7F, 4'b1011, mkf(20, 6, 'h7F)};
    tv[4] = '{1, 21, 1, 'h00, 4'b1101, mkf(21, 0, 'h00)};
    tv[5] = '{3, 22, 2, 'h55, 4'b0111, mkf(22, 1, 'h55)};
    tv[6] = '{2, 20, 5, 'h01, 4'b0000, '0};
    tv[7] = '{1, 7, 4, 'h33, 4'b1101, mkf(7, 3, 'h33)};

    rstn = 1'b1; iv = '0; ir = 4'hF;
    for (int p = 0; p < 4; p++) idat[p] = '0;
    clr_mon();
    repeat (2) @(negedge clk);
    chk("rst_valid", ov, 4'h0);
    chk("rst_ready", ordy, 4'hF);
    for (int p = 0; p < 4; p++) chk($sformatf("rst_data%0d", p), odat[p], 0);
    rstn = 1'b0;
    chk_on = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iv[tv[i].port] = 1'b1;
      idat[tv[i].port] = mkf(tv[i].id, tv[i].ttl, tv[i].pay);
      @(negedge clk);
      iv = '0;
      chk($sformatf("vec%0d_lat", i), ov, 4'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_mask", i), ov, tv[i].mask);
      for (int p = 0; p < 4; p++)
        if (tv[i].mask[p]) chk($sformatf("vec%0d_data%0d", i, p), odat[p], tv[i].dat);
      @(negedge clk);
      chk($sformatf("vec%0d_once", i), ov, 4'h0);
    end

    // Duplicate on B, then the same new ID on L and R in one cycle.
    @(negedge clk);
    clr_mon();
    iv[3] = 1'b1; idat[3] = mkf(5, 3, 1);
    @(negedge clk);
    iv = '0;
    repeat (3) @(negedge clk);
    iv[0] = 1'b1; idat[0] = mkf(9, 4, 'h12);
    iv[1] = 1'b1; idat[1] = mkf(9, 4, 'h34);
    @(negedge clk);
    iv = '0;
    repeat (5) @(negedge clk);
    for (int p = 0; p < 4; p++) chk($sformatf("dup5_p%0d", p), seen[p][5], 0);
    chk("dup9_l", seen[0][9], 0);
    for (int p = 1; p < 4; p++) chk($sformatf("dup9_p%0d", p), seen[p][9], 1);
    if (tq[2].size() > 0) chk("dup9_src_l", tq[2][0], mkf(9, 3, 'h12));
    else chk("dup9_t_present", 0, 1);

    // TTL expiry, then cache eviction boundary.
    clr_mon();
    iv[2] = 1'b1; idat[2] = mkf(30, 0, 0);
    @(negedge clk);
    iv = '0;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 4; p++) chk($sformatf("ttl0_p%0d", p), seen[p][30], 0);
    for (int id = 10; id <= 18; id++) send(0, mkf(id, 2, id));
    repeat (4) @(negedge clk);
    send(0, mkf(11, 2, 0));
    repeat (4) @(negedge clk);
    send(0, mkf(10, 2, 5));
    repeat (4) @(negedge clk);
    chk("wrap_11_kept", seen[1][11], 1);
    chk("wrap_10_evicted", seen[1][10], 2);
    chk("wrap_18", seen[2][18], 1);

    // Back-pressure on T.
    clr_mon();
    ir[2] = 1'b0;
    for (int k = 0; k < 5; k++) send(0, mkf(40 + k, 3, k));
    chk("bp_ready_low", ordy[0], 0);
    chk("bp_valid_t", ov[2], 1);
    chk("bp_rb_done", {ov[3], ov[1]}, 2'b00);
    chk("bp_r_once", seen[1][40], 1);
    chk("bp_b_once", seen[3][40], 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", ov[2], 1);
      chk("bp_hold_data", odat[2], mkf(40, 2, 0));
    end
    ir[2] = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_l_none", tq[0].size(), 0);
    for (int p = 1; p < 4; p++) begin
      chk($sformatf("bp_cnt%0d", p), tq[p].size(), 5);
      for (int k = 0; k < 5 && k < tq[p].size(); k++)
        chk($sformatf("bp_ord%0d_%0d", p, k), tq[p][k], mkf(40 + k, 2, k));
    end

    // Mid-operation reset with busy stage and non-empty FIFO.
    ir[2] = 1'b0;
    for (int k = 0; k < 3; k++) send(0, mkf(50 + k, 3, k));
    rstn = 1'b1;
    @(negedge clk);
    chk("mrst_valid", ov, 4'h0);
    chk("mrst_ready", ordy, 4'hF);
    rstn = 1'b0; ir = 4'hF;
    clr_mon();
    send(0, mkf(50, 3, 0));
    repeat (4) @(negedge clk);
    chk("mrst_resend_r", seen[1][50], 1);
    chk("mrst_resend_t", seen[2][50], 1);

    // Random traffic, small ID space so duplicates are common.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 4; p++) begin
        iv[p] = 1'($urandom_range(0, 1));
        idat[p] = mkf($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 127));
        ir[p] = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    rstn = 1'b0; iv = '0; ir = 4'hF;
    repeat (20) @(negedge clk);
    chk("drain_idle", ov, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
